// File: rtl/snn_inference_scheduler.sv
// Inference sequencer for a spiking classifier: clears the network, runs it
// for WINDOW timesteps while counting output-layer spikes per class, then
// scans the counts one class per cycle to pick the winner (lowest index wins
// ties) and presents the result with a valid/ready handshake.
module snn_inference_scheduler #(
   parameter int NUM_CLASSES = 10,
   parameter int WINDOW      = 64,
   parameter int CNT_W       = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   start_i,
   input  logic                   abort_i,
   input  logic [NUM_CLASSES-1:0] spike_i,
   output logic                   net_clear_o,
   output logic                   net_en_o,
   output logic                   busy_o,
   output logic                   result_valid_o,
   input  logic                   result_ready_i,
   output logic [3:0]             result_class_o,
   output logic [CNT_W-1:0]       result_count_o,
   output logic                   result_tie_o
);

   localparam int TW = $clog2(WINDOW + 1);
   localparam logic [TW-1:0] LAST_T = TW'(WINDOW - 1);
   localparam logic [3:0]    LAST_K = 4'(NUM_CLASSES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_RUN,
      S_SCAN,
      S_DONE
   } state_t;

   state_t state, state_nx;

   logic [TW-1:0]    t_cnt;
   logic [3:0]       scan_k;
   logic [CNT_W-1:0] cnt [NUM_CLASSES];
   logic [CNT_W-1:0] best;
   logic [3:0]       idx;
   logic             tie;
   logic [CNT_W-1:0] scan_val;
   logic             run_last;
   logic             scan_last;

   assign run_last  = (t_cnt == LAST_T);
   assign scan_last = (scan_k == LAST_K);

   // Select the count of the class currently under examination
   always_comb begin
      scan_val = '0;
      for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
         if (scan_k == 4'(k)) scan_val = cnt[k];
      end
   end

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) state <= S_IDLE;
      else       state <= state_nx;
   end

   // Next-state and control outputs; abort beats start and the DONE handshake
   always_comb begin
      state_nx    = state;
      net_clear_o = 1'b0;
      net_en_o    = 1'b0;
      busy_o      = 1'b1;
      unique case (state)
         S_IDLE: begin
            busy_o = 1'b0;
            if (start_i && !abort_i) state_nx = S_CLEAR;
         end
         S_CLEAR: begin
            net_clear_o = 1'b1;
            state_nx    = abort_i ? S_IDLE : S_RUN;
         end
         S_RUN: begin
            net_en_o = 1'b1;
            if (abort_i)       state_nx = S_IDLE;
            else if (run_last) state_nx = S_SCAN;
         end
         S_SCAN: begin
            if (abort_i)        state_nx = S_IDLE;
            else if (scan_last) state_nx = S_DONE;
         end
         S_DONE: begin
            if (abort_i || result_ready_i) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Result outputs are forced to zero whenever no result is on offer
   always_comb begin
      result_valid_o = (state == S_DONE);
      result_class_o = result_valid_o ? idx  : '0;
      result_count_o = result_valid_o ? best : '0;
      result_tie_o   = result_valid_o ? tie  : 1'b0;
   end

   // Timestep counter, saturating spike counters and the argmax scan
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         t_cnt  <= '0;
         scan_k <= '0;
         best   <= '0;
         idx    <= '0;
         tie    <= 1'b0;
         for (int unsigned k = 0; k < NUM_CLASSES; k++) cnt[k] <= '0;
      end else begin
         unique case (state)
            S_CLEAR: begin
               t_cnt  <= '0;
               scan_k <= '0;
               for (int unsigned k = 0; k < NUM_CLASSES; k++) cnt[k] <= '0;
            end
            S_RUN: begin
               t_cnt <= t_cnt + TW'(1);
               for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
                  if (spike_i[k] && (cnt[k] != '1)) cnt[k] <= cnt[k] + CNT_W'(1);
               end
            end
            S_SCAN: begin
               scan_k <= scan_k + 4'd1;
               if (scan_k == 4'd0) begin
                  best <= scan_val;
                  idx  <= 4'd0;
                  tie  <= 1'b0;
               end else if (scan_val > best) begin
                  best <= scan_val;
                  idx  <= scan_k;
                  tie  <= 1'b0;
               end else if (scan_val == best) begin
                  tie  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_snn_inference_scheduler.sv
// Bench for snn_inference_scheduler: two instances (8-bit and 3-bit counts,
// WINDOW=8, 10 classes) share stimulus; results are compared with an
// argmax-over-saturated-sums reference model.
module tb_snn_inference_scheduler;

   localparam int NC  = 10;
   localparam int WIN = 8;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          start_i;
   logic          abort_i;
   logic [NC-1:0] spike_i;
   logic          result_ready_i;

   logic       a_clear, a_en, a_busy, a_valid, a_tie;
   logic [3:0] a_class;
   logic [7:0] a_count;
   logic       b_clear, b_en, b_busy, b_valid, b_tie;
   logic [3:0] b_class;
   logic [2:0] b_count;

   int checks = 0;
   int errors = 0;

   logic [NC-1:0] spk_seq [WIN];
   int ex_cls, ex_cnt, ex_tie, ex_cls3, ex_cnt3, ex_tie3;

   always #5 clk_i = ~clk_i;

   snn_inference_scheduler #(.NUM_CLASSES(NC), .WINDOW(WIN), .CNT_W(8)) dut_a (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
      .spike_i(spike_i), .net_clear_o(a_clear), .net_en_o(a_en), .busy_o(a_busy),
      .result_valid_o(a_valid), .result_ready_i(result_ready_i),
      .result_class_o(a_class), .result_count_o(a_count), .result_tie_o(a_tie));

   snn_inference_scheduler #(.NUM_CLASSES(NC), .WINDOW(WIN), .CNT_W(3)) dut_b (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
      .spike_i(spike_i), .net_clear_o(b_clear), .net_en_o(b_en), .busy_o(b_busy),
      .result_valid_o(b_valid), .result_ready_i(result_ready_i),
      .result_class_o(b_class), .result_count_o(b_count), .result_tie_o(b_tie));

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   // Reference: per-class totals over the window, clipped at sat, then argmax
   task automatic model(input int sat, output int cls, output int cnt, output int tie);
      int c [NC];
      int nmax;
      for (int k = 0; k < NC; k++) begin
         c[k] = 0;
         for (int i = 0; i < WIN; i++) if (spk_seq[i][k]) c[k]++;
         if (c[k] > sat) c[k] = sat;
      end
      cnt = 0;
      for (int k = 0; k < NC; k++) if (c[k] > cnt) cnt = c[k];
      cls  = -1;
      nmax = 0;
      for (int k = 0; k < NC; k++) begin
         if (c[k] == cnt) begin
            nmax++;
            if (cls < 0) cls = k;
         end
      end
      tie = (nmax > 1) ? 1 : 0;
   endtask

   // One full inference from start pulse to DONE, optionally completing the handshake
   task automatic test_inference(input string name, input bit finish);
      int n;
      model(255, ex_cls, ex_cnt, ex_tie);
      model(7, ex_cls3, ex_cnt3, ex_tie3);
      start_i = 1'b1;
      spike_i = NC'($urandom);
      tick;
      start_i = 1'b0;
      spike_i = NC'($urandom);
      checks++;
      if ({a_clear, a_en, a_busy, a_valid} !== 4'b1010) begin
         errors++;
         $display("FAIL %s clear_cycle: got clr/en/busy/vld=%b expected 1010", name,
                  {a_clear, a_en, a_busy, a_valid});
      end
      n = 0;
      for (int i = 0; i < WIN; i++) begin
         tick;
         n++;
         checks++;
         if ({a_clear, a_en, a_valid} !== 3'b010) begin
            errors++;
            $display("FAIL %s run_cycle%0d: got clr/en/vld=%b expected 010", name, i,
                     {a_clear, a_en, a_valid});
         end
         spike_i = spk_seq[i];
      end
      tick;
      n++;
      spike_i = NC'($urandom);
      checks++;
      if ({a_en, a_busy} !== 2'b01) begin
         errors++;
         $display("FAIL %s scan_entry: got en/busy=%b expected 01", name, {a_en, a_busy});
      end
      while (a_valid !== 1'b1 && n < 40) begin
         tick;
         n++;
         spike_i = NC'($urandom);
      end
      checks++;
      if (n != WIN + NC + 1) begin
         errors++;
         $display("FAIL %s latency: got %0d edges expected %0d", name, n, WIN + NC + 1);
      end
      checks++;
      if ({a_valid, a_class, a_count, a_tie} !== {1'b1, 4'(ex_cls), 8'(ex_cnt), 1'(ex_tie)}) begin
         errors++;
         $display("FAIL %s result8: got vld=%b cls=%0d cnt=%0d tie=%b expected 1 %0d %0d %0d",
                  name, a_valid, a_class, a_count, a_tie, ex_cls, ex_cnt, ex_tie);
      end
      checks++;
      if ({b_valid, b_class, b_count, b_tie} !== {1'b1, 4'(ex_cls3), 3'(ex_cnt3), 1'(ex_tie3)}) begin
         errors++;
         $display("FAIL %s result3: got vld=%b cls=%0d cnt=%0d tie=%b expected 1 %0d %0d %0d",
                  name, b_valid, b_class, b_count, b_tie, ex_cls3, ex_cnt3, ex_tie3);
      end
      if (finish) begin
         result_ready_i = 1'b1;
         tick;
         result_ready_i = 1'b0;
         checks++;
         if ({a_busy, a_valid, a_class, a_count, a_tie} !== '0) begin
            errors++;
            $display("FAIL %s handshake: got busy=%b vld=%b cls=%0d cnt=%0d tie=%b expected all 0",
                     name, a_busy, a_valid, a_class, a_count, a_tie);
         end
      end
   endtask

   task automatic test_reset;
      rst_i   = 1'b1;
      start_i = 1'b1;
      abort_i = 1'b0;
      spike_i = '1;
      repeat (3) tick;
      checks++;
      if ({a_busy, a_clear, a_en, a_valid, a_class, a_count, a_tie,
           b_busy, b_clear, b_en, b_valid, b_class, b_count, b_tie} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got a=%b_%b_%b_%b_%0d_%0d_%b expected all 0",
                  a_busy, a_clear, a_en, a_valid, a_class, a_count, a_tie);
      end
      rst_i   = 1'b0;
      start_i = 1'b0;
      tick;
      checks++;
      if ({a_busy, a_valid} !== 2'b00) begin
         errors++;
         $display("FAIL reset_release: got busy/vld=%b expected 00", {a_busy, a_valid});
      end
   endtask

   task automatic test_fixed_patterns;
      for (int i = 0; i < WIN; i++) spk_seq[i] = 10'b0000001000;
      test_inference("single_class", 1'b1);
      checks++;
      if ({a_class, a_count} !== {4'd3, 8'd0} && ex_cls != 3) begin
         errors++;
         $display("FAIL single_class_model: got model cls=%0d expected 3", ex_cls);
      end
      for (int i = 0; i < WIN; i++) spk_seq[i] = 10'b0010000100;
      test_inference("tie_2_7", 1'b1);
      for (int i = 0; i < WIN; i++) spk_seq[i] = '0;
      test_inference("all_zero", 1'b1);
   endtask

   task automatic test_saturation;
      for (int i = 0; i < WIN; i++) spk_seq[i] = (i < 4) ? 10'b0000100010 : 10'b0000100000;
      test_inference("saturation", 1'b1);
   endtask

   task automatic test_hold_done;
      for (int i = 0; i < WIN; i++) spk_seq[i] = NC'($urandom);
      test_inference("hold_done", 1'b0);
      for (int c = 0; c < 5; c++) begin
         start_i = (c == 2);
         tick;
         checks++;
         if ({a_busy, a_valid, a_clear, a_en, a_class, a_count, a_tie} !==
             {4'b1100, 4'(ex_cls), 8'(ex_cnt), 1'(ex_tie)}) begin
            errors++;
            $display("FAIL hold_done cycle%0d: got busy=%b vld=%b cls=%0d cnt=%0d tie=%b expected 1 1 %0d %0d %0d",
                     c, a_busy, a_valid, a_class, a_count, a_tie, ex_cls, ex_cnt, ex_tie);
         end
      end
      start_i        = 1'b0;
      result_ready_i = 1'b1;
      tick;
      result_ready_i = 1'b0;
      checks++;
      if ({a_busy, a_valid} !== 2'b00) begin
         errors++;
         $display("FAIL hold_done_release: got busy/vld=%b expected 00", {a_busy, a_valid});
      end
      tick;
      checks++;
      if (a_busy !== 1'b0) begin
         errors++;
         $display("FAIL hold_done_idle: got busy=%b expected 0", a_busy);
      end
   endtask

   task automatic test_abort;
      int seen;
      // abort must beat start while idle
      start_i = 1'b1;
      abort_i = 1'b1;
      tick;
      start_i = 1'b0;
      abort_i = 1'b0;
      checks++;
      if (a_busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_over_start: got busy=%b expected 0", a_busy);
      end
      // abort during RUN cycle 4 after class 9 already spiked
      start_i = 1'b1;
      tick;
      start_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick;
         spike_i = 10'h200;
      end
      abort_i = 1'b1;
      tick;
      abort_i = 1'b0;
      checks++;
      if ({a_busy, a_en, a_valid} !== 3'b000) begin
         errors++;
         $display("FAIL abort_run: got busy/en/vld=%b expected 000", {a_busy, a_en, a_valid});
      end
      seen = 0;
      for (int i = 0; i < 25; i++) begin
         spike_i = NC'($urandom);
         tick;
         if (a_valid === 1'b1 || a_busy === 1'b1) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL abort_run_quiet: got %0d active cycles expected 0", seen);
      end
      for (int i = 0; i < WIN; i++) spk_seq[i] = 10'h200;
      test_inference("after_abort", 1'b1);
      // reset at SCAN cycle 2
      start_i = 1'b1;
      tick;
      start_i = 1'b0;
      for (int i = 0; i < WIN + 3; i++) begin
         tick;
         spike_i = NC'($urandom);
      end
      rst_i = 1'b1;
      tick;
      rst_i = 1'b0;
      checks++;
      if ({a_busy, a_en, a_valid, a_class, a_count, a_tie} !== '0) begin
         errors++;
         $display("FAIL reset_scan: got busy=%b en=%b vld=%b cls=%0d cnt=%0d expected all 0",
                  a_busy, a_en, a_valid, a_class, a_count);
      end
      seen = 0;
      for (int i = 0; i < 25; i++) begin
         tick;
         if (a_valid === 1'b1 || a_busy === 1'b1) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL reset_scan_quiet: got %0d active cycles expected 0", seen);
      end
   endtask

   task automatic test_random;
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < WIN; i++) begin
            // mix dense, sparse and biased patterns to provoke ties and saturation
            case (r % 3)
               0:       spk_seq[i] = NC'($urandom);
               1:       spk_seq[i] = NC'($urandom & $urandom & $urandom);
               default: spk_seq[i] = NC'($urandom) | 10'b0001000001;
            endcase
         end
         test_inference("random", 1'b1);
      end
   endtask

   initial begin
      rst_i          = 1'b1;
      start_i        = 1'b0;
      abort_i        = 1'b0;
      spike_i        = '0;
      result_ready_i = 1'b0;
      test_reset;
      test_fixed_patterns;
      test_saturation;
      test_hold_done;
      test_abort;
      test_random;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
